gpu_pixel_writer: RTL and testbench



---
 rtl/gpu_pixel_writer.sv | 181 ++++++++++++++++++
 tb/tb_gpu_pixel_writer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_pixel_writer.sv
// ============================================================================
// Module      : gpu_pixel_writer
// Description : Buffers rasterizer points in a FIFO and issues one framebuffer
//               write per point over a req/ack handshake. Define
//               GPU_PIXWR_CLIP_EN to discard off-screen points and count them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpu_pixel_writer #(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int ADDR_BITS    = 19,
    parameter int BASE_ADDR    = 0,
    parameter int CHANNEL_BITS = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_valid,
    input  logic [WIDTH_BITS-1:0]     pix_x,
    input  logic [HEIGHT_BITS-1:0]    pix_y,
    input  logic [3*CHANNEL_BITS-1:0] pix_color,
    input  logic                      pix_last,
    output logic                      pix_ready,
    output logic                      mem_req,
    output logic [ADDR_BITS-1:0]      mem_addr,
    output logic [3*CHANNEL_BITS-1:0] mem_data,
    input  logic                      mem_ack,
    output logic                      busy_o,
`ifdef GPU_PIXWR_CLIP_EN
    output logic [15:0]               clip_cnt,
`endif
    output logic                      done_o
);

    localparam int c_PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int c_COLOR_BITS = 3 * CHANNEL_BITS;
    // Wide enough that y*WIDTH + x + BASE_ADDR never wraps before truncation.
    localparam int c_CALC_BITS  = ADDR_BITS + WIDTH_BITS + HEIGHT_BITS + 2;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (WIDTH > (1 << WIDTH_BITS)) || (HEIGHT > (1 << HEIGHT_BITS))) begin : g_bad_params
        $error("gpu_pixel_writer: illegal parameter combination");
    end

    typedef struct packed {
        logic [WIDTH_BITS-1:0]   x;
        logic [HEIGHT_BITS-1:0]  y;
        logic [c_COLOR_BITS-1:0] color;
        logic                    last;
    } point_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    point_t                r_fifo [FIFO_DEPTH];
    logic [c_PTR_BITS:0]   r_wr_ptr;
    logic [c_PTR_BITS:0]   r_rd_ptr;
    state_t                r_state;
    state_t                w_next_state;
    logic                  r_cur_last;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_clip_pop;
    logic                  w_ack;
    logic                  w_keep;
    point_t                w_head;
    logic [c_CALC_BITS-1:0] w_addr_wide;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_BITS] != r_rd_ptr[c_PTR_BITS]) &&
                     (r_wr_ptr[c_PTR_BITS-1:0] == r_rd_ptr[c_PTR_BITS-1:0]);
    assign w_push  = pix_valid && !w_full;
    assign w_head  = r_fifo[r_rd_ptr[c_PTR_BITS-1:0]];
    assign w_ack   = (r_state == S_WRITE) && mem_ack;

    assign w_addr_wide = c_CALC_BITS'(w_head.y) * c_CALC_BITS'(WIDTH)
                       + c_CALC_BITS'(w_head.x) + c_CALC_BITS'(BASE_ADDR);

`ifdef GPU_PIXWR_CLIP_EN
    // Underflowed coordinates arrive as large unsigned values and fail here too.
    assign w_keep = (c_CALC_BITS'(w_head.x) < c_CALC_BITS'(WIDTH)) &&
                    (c_CALC_BITS'(w_head.y) < c_CALC_BITS'(HEIGHT));
`else
    assign w_keep = 1'b1;
`endif

    assign w_clip_pop = w_pop && !w_keep;

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_keep) begin
                        w_load       = 1'b1;
                        w_next_state = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    w_next_state = S_IDLE;
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_keep) begin
                            w_load       = 1'b1;
                            w_next_state = S_WRITE;
                        end
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_PTR_BITS-1:0]] <= {pix_x, pix_y, pix_color, pix_last};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_state    <= S_IDLE;
            r_cur_last <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            done_o     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_load) begin
                mem_addr   <= w_addr_wide[ADDR_BITS-1:0];
                mem_data   <= w_head.color;
                r_cur_last <= w_head.last;
            end
            // Retiring write and retiring clipped point can coincide; one pulse covers both.
            done_o <= (w_ack && r_cur_last) || (w_clip_pop && w_head.last);
        end
    end

`ifdef GPU_PIXWR_CLIP_EN
    logic [15:0] r_clip_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clip_cnt <= '0;
        end else if (w_clip_pop && (r_clip_cnt != 16'hFFFF)) begin
            r_clip_cnt <= r_clip_cnt + 16'd1;
        end
    end

    assign clip_cnt = r_clip_cnt;
`endif

    assign pix_ready = !w_full;
    assign mem_req   = (r_state == S_WRITE);
    assign busy_o    = !w_empty || mem_req;

endmodule

`default_nettype wire

// File: tb/tb_gpu_pixel_writer.sv
// ============================================================================
// Module      : tb_gpu_pixel_writer
// Description : Randomised and directed bench for gpu_pixel_writer against a
//               queue-based point model; honours GPU_PIXWR_CLIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpu_pixel_writer;

    localparam int W     = 640;
    localparam int H     = 480;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [23:0] pix_color;
    logic        pix_last;
    logic        pix_ready;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic [23:0] mem_data;
    logic        mem_ack;
    logic        busy_o;
    logic        done_o;
`ifdef GPU_PIXWR_CLIP_EN
    logic [15:0] clip_cnt;
`endif

    gpu_pixel_writer dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .pix_last  (pix_last),
        .pix_ready (pix_ready),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ack   (mem_ack),
        .busy_o    (busy_o),
`ifdef GPU_PIXWR_CLIP_EN
        .clip_cnt  (clip_cnt),
`endif
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] color;
        bit          last;
    } pt_t;

    pt_t         fifo_q[$];
    int          wr_log[$];
    bit          m_req;
    bit          m_last;
    bit          m_done;
    int          m_addr;
    logic [23:0] m_data;
    int          m_clip;
    int          errors = 0;
    int          checks = 0;
    int          n_acc  = 0;
    int          n_done = 0;

    function automatic bit keep_pt(pt_t p);
`ifdef GPU_PIXWR_CLIP_EN
        return (p.x < W) && (p.y < H);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int addr_of(pt_t p);
        return (p.y * W + p.x) % (1 << 19);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs held at that edge.
    task automatic model_edge();
        bit  push;
        bit  ack;
        bit  ret;
        pt_t p;
        if (rst) begin
            fifo_q.delete();
            m_req  = 1'b0;
            m_last = 1'b0;
            m_done = 1'b0;
            m_addr = 0;
            m_data = '0;
            m_clip = 0;
            return;
        end
        push = pix_valid && (fifo_q.size() < DEPTH);
        ack  = m_req && mem_ack;
        ret  = 1'b0;
        if (ack) begin
            ret   = m_last;
            m_req = 1'b0;
            wr_log.push_back(m_addr);
        end
        if ((fifo_q.size() > 0) && !m_req) begin
            p = fifo_q.pop_front();
            if (keep_pt(p)) begin
                m_req  = 1'b1;
                m_addr = addr_of(p);
                m_data = p.color;
                m_last = p.last;
            end else begin
                if (m_clip < 65535) m_clip++;
                if (p.last) ret = 1'b1;
            end
        end
        if (push) begin
            p.x     = int'(pix_x);
            p.y     = int'(pix_y);
            p.color = pix_color;
            p.last  = pix_last;
            fifo_q.push_back(p);
            n_acc++;
        end
        m_done = ret;
        if (ret) n_done++;
    endtask

    task automatic compare();
        check("pix_ready", int'(pix_ready), int'(fifo_q.size() < DEPTH));
        check("mem_req",   int'(mem_req),   int'(m_req));
        check("busy_o",    int'(busy_o),    int'((fifo_q.size() > 0) || m_req));
        check("done_o",    int'(done_o),    int'(m_done));
        if (m_req) begin
            check("mem_addr", int'(mem_addr), m_addr);
            check("mem_data", int'(mem_data), int'(m_data));
        end
`ifdef GPU_PIXWR_CLIP_EN
        check("clip_cnt", int'(clip_cnt), m_clip);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input bit v, input int x, input int y, input logic [23:0] c, input bit l);
        pix_valid = v;
        pix_x     = 10'(x);
        pix_y     = 9'(y);
        pix_color = c;
        pix_last  = l;
    endtask

    initial begin
        int acc0;
        int done0;
        int req_cycles;
        int cx[5];
        int cy[5];
        drive(0, 0, 0, 24'h0, 0);
        mem_ack = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_edge();
        check("reset pix_ready", int'(pix_ready), 1);
        check("reset mem_req",   int'(mem_req),   0);
        check("reset mem_addr",  int'(mem_addr),  0);
        check("reset mem_data",  int'(mem_data),  0);
        check("reset busy_o",    int'(busy_o),    0);
        check("reset done_o",    int'(done_o),    0);
`ifdef GPU_PIXWR_CLIP_EN
        check("reset clip_cnt",  int'(clip_cnt),  0);
`endif
        rst = 1'b0;

        // Single point, ack tied high: write at 2*640+3 the cycle after acceptance.
        mem_ack = 1'b1;
        drive(1, 3, 2, 24'hFF0000, 1);
        step();
        drive(0, 0, 0, 24'h0, 0);
        step();
        check("t1 req",  int'(mem_req),  1);
        check("t1 addr", int'(mem_addr), 1283);
        check("t1 data", int'(mem_data), 24'hFF0000);
        step();
        check("t1 done", int'(done_o), 1);
        step();
        check("t1 done once", int'(done_o), 0);
        check("t1 idle",      int'(busy_o), 0);

        // Back-pressure: one point parks in the write register, eight fill the FIFO.
        mem_ack = 1'b0;
        acc0 = n_acc;
        wr_log.delete();
        for (int i = 0; i < 9; i++) begin
            drive(1, 10 + i, 20, 24'(i * 24'h010203), 0);
            step();
        end
        check("t2 full", int'(pix_ready), 0);
        drive(1, 99, 99, 24'hABCDEF, 0);
        step();
        step();
        check("t2 accepted", n_acc - acc0, 9);
        drive(0, 0, 0, 24'h0, 0);
        mem_ack = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("t2 writes", wr_log.size(), 9);

        // Streaming: four points back to back, four adjacent request cycles.
        wr_log.delete();
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 100 + i, 50, 24'h00FF00, 0);
            step();
            req_cycles += int'(mem_req);
        end
        drive(0, 0, 0, 24'h0, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            req_cycles += int'(mem_req);
        end
        check("t3 req cycles", req_cycles, 4);
        check("t3 writes", wr_log.size(), 4);

        // Clip candidates.
        wr_log.delete();
        done0 = n_done;
        drive(1, 640, 0, 24'h111111, 0);  step();
        drive(1, 1023, 5, 24'h222222, 0); step();
        drive(1, 0, 480, 24'h333333, 0);  step();
        drive(1, 10, 10, 24'h444444, 1);  step();
        drive(0, 0, 0, 24'h0, 0);
        for (int i = 0; i < 8; i++) step();
        check("t4 done", n_done - done0, 1);
`ifdef GPU_PIXWR_CLIP_EN
        check("t4 writes", wr_log.size(), 1);
        check("t4 clip_cnt", int'(clip_cnt), 3);
        if (wr_log.size() > 0) check("t4 addr", wr_log[0], 6410);
`else
        check("t4 writes", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            check("t4 addr0", wr_log[0], 640);
            check("t4 addr3", wr_log[3], 6410);
        end
`endif

        // Reset while a write is pending with three points buffered.
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 5 + i, 7, 24'h0000FF, 1);
            step();
        end
        drive(0, 0, 0, 24'h0, 0);
        check("t5 req before rst", int'(mem_req), 1);
        check("t5 buffered", fifo_q.size(), 3);
        done0 = n_done;
        rst = 1'b1;
        #1;
        check("t5 async req", int'(mem_req), 0);
        check("t5 async busy", int'(busy_o), 0);
        step();
        rst = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t5 ready", int'(pix_ready), 1);
        check("t5 no done", n_done - done0, 0);

        // Octant-0 circle, radius 5, centre (100,100).
        cx[0] = 0; cx[1] = 1; cx[2] = 2; cx[3] = 3; cx[4] = 4;
        cy[0] = 5; cy[1] = 5; cy[2] = 5; cy[3] = 4; cy[4] = 4;
        wr_log.delete();
        done0 = n_done;
        for (int i = 0; i < 5; i++) begin
            drive(1, 100 + cx[i], 100 + cy[i], 24'hC0FFEE, i == 4);
            step();
        end
        drive(0, 0, 0, 24'h0, 0);
        for (int i = 0; i < 6; i++) step();
        check("t6 writes", wr_log.size(), 5);
        check("t6 done", n_done - done0, 1);
        if (wr_log.size() > 0) check("t6 first addr", wr_log[0], 67300);

        // Random traffic including off-screen coordinates.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)) % 720,
                  int'($urandom_range(0, 511)), 24'($urandom), $urandom_range(0, 4) == 0);
            mem_ack = ($urandom_range(0, 2) != 0);
            step();
        end
        drive(0, 0, 0, 24'h0, 0);
        mem_ack = 1'b1;
        for (int i = 0; i < 40 && busy_o; i++) step();
        check("drain busy", int'(busy_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
